// File: rtl/minimips_mem_responder.sv
// Responder end of the miniMIPS memory bus: frames transfers from a start pulse,
// checks each beat, inserts wait states and serves a word-organised RAM window.
module minimips_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        UFRGS_miniMIPS_clock,
    input  logic        UFRGS_miniMIPS_reset,
    input  logic        UFRGS_miniMIPS_start,
    input  logic [31:0] UFRGS_miniMIPS_addr,
    input  logic [1:0]  UFRGS_miniMIPS_size,
    input  logic        UFRGS_miniMIPS_read,
    input  logic        UFRGS_miniMIPS_write,
    input  logic        UFRGS_miniMIPS_bip,
    inout  wire  [31:0] UFRGS_miniMIPS_data,
    output logic        UFRGS_miniMIPS_wait,
    output logic        UFRGS_miniMIPS_error
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wait_q, wait_d;
    logic        error_q, error_d;
    logic        drive_q, drive_d;
    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] next_addr;
    logic [3:0]  lane_en;
    logic        mem_we;

    function automatic logic in_window(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic bad_request(input logic rd, input logic wr,
                                         input logic [31:0] a, input logic [1:0] sz);
        return (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) || !in_window(a);
    endfunction

    // Lane enables and burst increment both follow the transfer size.
    always_comb begin
        lane_en   = 4'b0000;
        next_addr = addr_q + 32'd4;
        case (size_q)
            2'b00: begin
                lane_en   = 4'b0001 << addr_q[1:0];
                next_addr = addr_q + 32'd1;
            end
            2'b01: begin
                lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                next_addr = addr_q + 32'd2;
            end
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (UFRGS_miniMIPS_start) state_d = ADDR;
            ADDR: begin
                addr_d = UFRGS_miniMIPS_addr;
                size_d = UFRGS_miniMIPS_size;
                rd_d   = UFRGS_miniMIPS_read;
                wr_d   = UFRGS_miniMIPS_write;
                if (!UFRGS_miniMIPS_read && !UFRGS_miniMIPS_write) begin
                    state_d = IDLE;
                end else if (bad_request(UFRGS_miniMIPS_read, UFRGS_miniMIPS_write,
                                         UFRGS_miniMIPS_addr, UFRGS_miniMIPS_size)) begin
                    state_d = ERR;
                end else if (WAIT_STATES == 0) begin
                    state_d = DATA;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 3'(WAIT_STATES);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = DATA;
            end
            DATA: begin
                if (!UFRGS_miniMIPS_bip) begin
                    state_d = IDLE;
                end else begin
                    // Alignment is preserved by the size-sized step; only the window is rechecked.
                    addr_d = next_addr;
                    if (!in_window(next_addr)) begin
                        state_d = ERR;
                    end else if (WAIT_STATES == 0) begin
                        state_d = DATA;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wait_d  = (state_d == WAIT);
        error_d = (state_d == ERR);
        drive_d = (state_d == DATA) && rd_d;
    end

    always_ff @(posedge UFRGS_miniMIPS_clock) begin
        if (UFRGS_miniMIPS_reset) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= 3'd0;
            wait_q  <= 1'b0;
            error_q <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            drive_q <= drive_d;
        end
    end

    // A write beat cut short by reset must not reach the array.
    assign mem_we = (state_q == DATA) && wr_q && !UFRGS_miniMIPS_reset;

    always_ff @(posedge UFRGS_miniMIPS_clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[word_index(addr_q)][8*b +: 8] <= UFRGS_miniMIPS_data[8*b +: 8];
            end
        end
        if (drive_d) rdata_q <= mem[word_index(addr_d)];
    end

    assign UFRGS_miniMIPS_data  = drive_q ? rdata_q : 32'bz;
    assign UFRGS_miniMIPS_wait  = wait_q;
    assign UFRGS_miniMIPS_error = error_q;

endmodule

// File: tb/tb_minimips_mem_responder.sv
// Directed bench for minimips_mem_responder: table of single transfers plus
// hand-written burst, ignored-start and reset-during-write sequences.
module tb_minimips_mem_responder;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 32;
    localparam int          WS    = 1;
    localparam int          NVEC  = 17;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_waits;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bus_addr = 32'h0;
    logic [1:0]  bus_size = 2'b00;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_bip = 1'b0;
    logic [31:0] tb_drv = 32'h0;
    logic        tb_oe = 1'b0;
    wire  [31:0] data_bus;
    logic        wait_o;
    logic        error_o;

    int          total = 0;
    int          bad = 0;
    int          obs_waits;
    int          obs_beats;
    logic        obs_err;
    logic        obs_err_once;
    logic        obs_idle;
    logic        obs_timeout;
    logic [31:0] obs_rdata;
    vec_t        vecs [NVEC];
    int          rst_cycles;
    logic        rst_seen_wait;

    assign data_bus = tb_oe ? tb_drv : 32'bz;

    always #5 clk = ~clk;

    minimips_mem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .UFRGS_miniMIPS_clock(clk),
        .UFRGS_miniMIPS_reset(reset),
        .UFRGS_miniMIPS_start(start),
        .UFRGS_miniMIPS_addr (bus_addr),
        .UFRGS_miniMIPS_size (bus_size),
        .UFRGS_miniMIPS_read (bus_read),
        .UFRGS_miniMIPS_write(bus_write),
        .UFRGS_miniMIPS_bip  (bus_bip),
        .UFRGS_miniMIPS_data (data_bus),
        .UFRGS_miniMIPS_wait (wait_o),
        .UFRGS_miniMIPS_error(error_o)
    );

    // Undriven bus reads as Z in four-state simulators and as zero in two-state ones.
    function automatic logic bus_idle();
        return (data_bus === 32'bz) || (data_bus === 32'h0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wdata,
                                 input int beats, input logic start_in_wait);
        int   cycles;
        logic pulsed;
        logic done;
        cycles       = 0;
        pulsed       = 1'b0;
        done         = 1'b0;
        obs_waits    = 0;
        obs_beats    = 0;
        obs_err      = 1'b0;
        obs_err_once = 1'b1;
        obs_idle     = 1'b1;
        obs_timeout  = 1'b0;
        obs_rdata    = 32'h0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        bus_addr  = addr;
        bus_size  = size;
        bus_read  = rd;
        bus_write = wr;
        if (!rd && !wr) begin
            @(negedge clk);
            obs_waits = int'(wait_o);
            obs_err   = error_o;
            obs_idle  = bus_idle();
        end else begin
            while (!done) begin
                @(negedge clk);
                cycles++;
                start   = 1'b0;
                tb_oe   = 1'b0;
                bus_bip = 1'b0;
                #1;
                if (cycles > 40) begin
                    obs_timeout = 1'b1;
                    done        = 1'b1;
                end else if (error_o) begin
                    obs_err  = 1'b1;
                    obs_idle = bus_idle();
                    @(negedge clk);
                    if (error_o) obs_err_once = 1'b0;
                    done = 1'b1;
                end else if (wait_o) begin
                    obs_waits++;
                    if (start_in_wait && !pulsed) begin
                        start  = 1'b1;
                        pulsed = 1'b1;
                    end
                end else if (obs_beats == beats) begin
                    obs_idle = bus_idle();
                    done     = 1'b1;
                end else begin
                    if (rd && obs_beats == 0) obs_rdata = data_bus;
                    if (wr) begin
                        tb_drv = wdata + 32'(obs_beats);
                        tb_oe  = 1'b1;
                    end
                    bus_bip = (obs_beats < beats - 1);
                    obs_beats++;
                end
            end
        end
        start     = 1'b0;
        bus_addr  = 32'h0;
        bus_size  = 2'b00;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        bus_bip   = 1'b0;
        tb_oe     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{"wr_word_10",   1'b0, 1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 1'b0, 1, 1'b0, 32'h0};
        vecs[1]  = '{"rd_word_10",   1'b1, 1'b0, 32'h10, 2'b10, 32'h0,        1'b0, 1, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{"wr_word_20",   1'b0, 1'b1, 32'h20, 2'b10, 32'h0,        1'b0, 1, 1'b0, 32'h0};
        vecs[3]  = '{"wr_byte_22",   1'b0, 1'b1, 32'h22, 2'b00, 32'h11AA3344, 1'b0, 1, 1'b0, 32'h0};
        vecs[4]  = '{"wr_half_20",   1'b0, 1'b1, 32'h20, 2'b01, 32'h99881234, 1'b0, 1, 1'b0, 32'h0};
        vecs[5]  = '{"rd_word_20",   1'b1, 1'b0, 32'h20, 2'b10, 32'h0,        1'b0, 1, 1'b1, 32'h00AA1234};
        vecs[6]  = '{"rd_byte_23",   1'b1, 1'b0, 32'h23, 2'b00, 32'h0,        1'b0, 1, 1'b1, 32'h00AA1234};
        vecs[7]  = '{"wr_word_40",   1'b0, 1'b1, 32'h40, 2'b10, 32'h0,        1'b0, 1, 1'b0, 32'h0};
        vecs[8]  = '{"err_misalign", 1'b1, 1'b0, 32'h13, 2'b10, 32'h0,        1'b1, 0, 1'b0, 32'h0};
        vecs[9]  = '{"err_size11",   1'b1, 1'b0, 32'h10, 2'b11, 32'h0,        1'b1, 0, 1'b0, 32'h0};
        vecs[10] = '{"err_rd_wr",    1'b1, 1'b1, 32'h10, 2'b10, 32'h12345678, 1'b1, 0, 1'b0, 32'h0};
        vecs[11] = '{"err_range",    1'b0, 1'b1, BASE + 32'(4 * DEPTH), 2'b10, 32'h0, 1'b1, 0, 1'b0, 32'h0};
        vecs[12] = '{"err_half_odd", 1'b0, 1'b1, 32'h11, 2'b01, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 32'h0};
        vecs[13] = '{"rd_after_err", 1'b1, 1'b0, 32'h10, 2'b10, 32'h0,        1'b0, 1, 1'b1, 32'hDEADBEEF};
        vecs[14] = '{"noop",         1'b0, 1'b0, 32'h10, 2'b10, 32'h0,        1'b0, 0, 1'b0, 32'h0};
        vecs[15] = '{"wr_byte_13",   1'b0, 1'b1, 32'h13, 2'b00, 32'h77000000, 1'b0, 1, 1'b0, 32'h0};
        vecs[16] = '{"rd_lane3",     1'b1, 1'b0, 32'h10, 2'b10, 32'h0,        1'b0, 1, 1'b1, 32'h77ADBEEF};

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("reset_wait", 32'(wait_o), 32'h0);
        checkOutput("reset_error", 32'(error_o), 32'h0);
        checkOutput("reset_bus_z", 32'(bus_idle()), 32'h1);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1, 1'b0);
            checkOutput({vecs[i].name, "_timeout"}, 32'(obs_timeout), 32'h0);
            checkOutput({vecs[i].name, "_err"}, 32'(obs_err), 32'(vecs[i].exp_err));
            checkOutput({vecs[i].name, "_waits"}, 32'(obs_waits), 32'(vecs[i].exp_waits));
            checkOutput({vecs[i].name, "_bus_z"}, 32'(obs_idle), 32'h1);
            if (vecs[i].chk_rd) checkOutput({vecs[i].name, "_rdata"}, obs_rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_err) checkOutput({vecs[i].name, "_err_once"}, 32'(obs_err_once), 32'h1);
        end

        $display("[TB] burst crossing window end");
        applyStimulus(1'b0, 1'b1, BASE + 32'(4 * (DEPTH - 2)), 2'b10, 32'hB0B00000, 3, 1'b0);
        checkOutput("burst_timeout", 32'(obs_timeout), 32'h0);
        checkOutput("burst_err", 32'(obs_err), 32'h1);
        checkOutput("burst_beats", 32'(obs_beats), 32'h2);
        checkOutput("burst_waits", 32'(obs_waits), 32'h2);
        checkOutput("burst_err_once", 32'(obs_err_once), 32'h1);
        applyStimulus(1'b1, 1'b0, BASE + 32'(4 * (DEPTH - 2)), 2'b10, 32'h0, 1, 1'b0);
        checkOutput("burst_beat0_data", obs_rdata, 32'hB0B00000);
        applyStimulus(1'b1, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 2'b10, 32'h0, 1, 1'b0);
        checkOutput("burst_beat1_data", obs_rdata, 32'hB0B00001);

        $display("[TB] start pulsed during wait");
        applyStimulus(1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1, 1'b1);
        checkOutput("ign_start_err", 32'(obs_err), 32'h0);
        checkOutput("ign_start_waits", 32'(obs_waits), 32'h1);
        checkOutput("ign_start_rdata", obs_rdata, 32'h77ADBEEF);
        checkOutput("ign_start_bus_z", 32'(obs_idle), 32'h1);
        @(negedge clk);
        checkOutput("ign_start_after_wait", 32'(wait_o), 32'h0);

        $display("[TB] reset during write data beat");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        bus_addr  = 32'h40;
        bus_size  = 2'b10;
        bus_write = 1'b1;
        rst_cycles    = 0;
        rst_seen_wait = 1'b0;
        do begin
            @(negedge clk);
            rst_cycles++;
            if (wait_o) rst_seen_wait = 1'b1;
        end while (!(rst_seen_wait && !wait_o) && rst_cycles < 20);
        checkOutput("rst_reach_data", 32'(rst_cycles < 20), 32'h1);
        tb_drv = 32'h5555AAAA;
        tb_oe  = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        tb_oe     = 1'b0;
        bus_write = 1'b0;
        bus_addr  = 32'h0;
        #1;
        checkOutput("rst_wait", 32'(wait_o), 32'h0);
        checkOutput("rst_error", 32'(error_o), 32'h0);
        checkOutput("rst_bus_z", 32'(bus_idle()), 32'h1);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h40, 2'b10, 32'h0, 1, 1'b0);
        checkOutput("rst_readback", obs_rdata, 32'h0);
        checkOutput("rst_readback_err", 32'(obs_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
